// File: rtl/bcd_scan_counter_if.sv
// Control/display bundle between the user controls, the BCD counter and the 7-segment decoder.
interface bcd_scan_counter_if;
  logic       en;
  logic       up;
  logic       clear;
  logic [3:0] digit;
  logic [1:0] digit_sel;
  logic       blank;
  logic       wrap;

  modport master (output en, up, clear, input digit, digit_sel, blank, wrap);
  modport slave  (input en, up, clear, output digit, digit_sel, blank, wrap);
endinterface

// File: rtl/bcd_scan_counter.sv
// Two-digit BCD up/down counter with a two-slot digit scanner and leading-zero blanking.
module bcd_scan_counter #(
  parameter int TICK_DIV = 1000000,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                clk,
  input  logic                rst,
  bcd_scan_counter_if.slave   bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [SW-1:0] scan;
  logic          slot;
  logic [3:0]    ones, tens;
  logic [3:0]    ones_nx, tens_nx;
  logic          wrap_nx;
  logic          tick;

  logic [3:0]    digit_q;
  logic [1:0]    digit_sel_q;
  logic          blank_q;
  logic          wrap_q;

  assign tick = bus.en && (presc == PRESC_LAST);

  // Prescaler holds its position while en is low so a paused count resumes mid-step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (bus.clear) begin
      presc <= '0;
    end else if (bus.en) begin
      if (tick) presc <= '0;
      else      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    ones_nx = ones;
    tens_nx = tens;
    wrap_nx = 1'b0;
    if (tick) begin
      if (bus.up) begin
        if (ones != 4'd9) begin
          ones_nx = ones + 4'd1;
        end else begin
          ones_nx = 4'd0;
          if (tens != 4'd9) begin
            tens_nx = tens + 4'd1;
          end else begin
            tens_nx = 4'd0;
            wrap_nx = 1'b1;
          end
        end
      end else begin
        if (ones != 4'd0) begin
          ones_nx = ones - 4'd1;
        end else begin
          ones_nx = 4'd9;
          if (tens != 4'd0) begin
            tens_nx = tens - 4'd1;
          end else begin
            tens_nx = 4'd9;
            wrap_nx = 1'b1;
          end
        end
      end
    end
  end

  // clear wins over a coincident tick: no step and no wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones   <= 4'd0;
      tens   <= 4'd0;
      wrap_q <= 1'b0;
    end else if (bus.clear) begin
      ones   <= 4'd0;
      tens   <= 4'd0;
      wrap_q <= 1'b0;
    end else begin
      ones   <= ones_nx;
      tens   <= tens_nx;
      wrap_q <= wrap_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan <= '0;
      slot <= 1'b0;
    end else if (scan == SCAN_LAST) begin
      scan <= '0;
      slot <= ~slot;
    end else begin
      scan <= scan + 1'b1;
    end
  end

  // Ones digit is never blanked so a zero count still shows "0".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q     <= 4'd0;
      digit_sel_q <= 2'b01;
      blank_q     <= 1'b0;
    end else begin
      digit_q     <= slot ? tens : ones;
      digit_sel_q <= slot ? 2'b10 : 2'b01;
      blank_q     <= slot && (BLANK_LZ != 0) && (tens == 4'd0);
    end
  end

  assign bus.digit     = digit_q;
  assign bus.digit_sel = digit_sel_q;
  assign bus.blank     = blank_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with TICK_DIV=4, SCAN_DIV=3, BLANK_LZ=1.
module tb_bcd_scan_counter;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  int   wrap_cnt;
  int   wrap_run;
  int   wrap_max;

  bcd_scan_counter_if bus ();

  bcd_scan_counter #(.TICK_DIV(4), .SCAN_DIV(3), .BLANK_LZ(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.wrap === 1'b1) begin
      wrap_cnt++;
      wrap_run++;
      if (wrap_run > wrap_max) wrap_max = wrap_run;
    end else begin
      wrap_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_en(input int n);
    bus.en = 1'b1;
    tick_n(n);
    bus.en = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick_n(1);
    bus.clear = 1'b0;
  endtask

  // Collect both scan slots with en low so the count is frozen.
  task automatic read_count(input string tag, output logic [3:0] t, output logic [3:0] o,
                            output logic bt);
    bit got_t, got_o;
    got_t = 0; got_o = 0; t = 4'hf; o = 4'hf; bt = 1'bx;
    for (int i = 0; i < 10 && !(got_t && got_o); i++) begin
      tick_n(1);
      if (bus.digit_sel == 2'b01) begin
        o = bus.digit; got_o = 1;
        check({tag, "_ones_blank"}, bus.blank, 0);
      end else if (bus.digit_sel == 2'b10) begin
        t = bus.digit; bt = bus.blank; got_t = 1;
      end
    end
    check({tag, "_read_done"}, got_t && got_o, 1);
  endtask

  task automatic expect_count(input string tag, input int exp_t, input int exp_o);
    logic [3:0] t, o;
    logic bt;
    read_count(tag, t, o, bt);
    check({tag, "_tens"}, t, exp_t);
    check({tag, "_ones"}, o, exp_o);
  endtask

  initial begin
    logic [1:0] s [12];
    logic [3:0] t, o;
    logic       bt;
    int         w0, first, k;
    bit         found;

    n_chk = 0; n_err = 0; wrap_cnt = 0; wrap_run = 0; wrap_max = 0;
    rst = 1'b0; bus.en = 1'b0; bus.up = 1'b1; bus.clear = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_digit", bus.digit, 0);
    check("rst_sel", bus.digit_sel, 2'b01);
    check("rst_blank", bus.blank, 0);
    check("rst_wrap", bus.wrap, 0);
    tick_n(2);
    rst = 1'b0;

    // up count 40 cycles -> 10
    w0 = wrap_cnt;
    run_en(40);
    expect_count("up40", 1, 0);
    check("up40_nowrap", wrap_cnt - w0, 0);

    // up wrap
    pulse_clear();
    run_en(396);
    expect_count("load99", 9, 9);
    check("load99_nowrap", wrap_cnt - w0, 0);
    run_en(4);
    expect_count("upwrap", 0, 0);
    check("upwrap_pulses", wrap_cnt - w0, 1);
    check("upwrap_width", wrap_max, 1);

    // down wrap
    bus.up = 1'b0;
    run_en(4);
    expect_count("dnwrap", 9, 9);
    check("dnwrap_pulses", wrap_cnt - w0, 2);
    run_en(4);
    expect_count("dn98", 9, 8);
    check("dn98_pulses", wrap_cnt - w0, 2);

    // clear coincident with tick at 05
    bus.up = 1'b1;
    pulse_clear();
    run_en(20);
    expect_count("at05", 0, 5);
    w0 = wrap_cnt;
    run_en(3);
    bus.en = 1'b1; bus.clear = 1'b1;
    tick_n(1);
    bus.en = 1'b0; bus.clear = 1'b0;
    expect_count("clr_tick", 0, 0);
    check("clr_tick_nowrap", wrap_cnt - w0, 0);
    run_en(3);
    expect_count("clr_3cyc", 0, 0);
    run_en(1);
    expect_count("clr_4cyc", 0, 1);

    // hold mid-prescale at 03
    run_en(8);
    expect_count("at03", 0, 3);
    run_en(2);
    tick_n(20);
    expect_count("hold", 0, 3);
    run_en(1);
    expect_count("resume3", 0, 3);
    run_en(1);
    expect_count("resume4", 0, 4);

    // scan and blank at 07
    pulse_clear();
    run_en(28);
    expect_count("at07", 0, 7);
    for (int i = 0; i < 12; i++) begin
      tick_n(1);
      s[i] = bus.digit_sel;
      check("scan_onehot", $onehot(bus.digit_sel), 1);
      if (bus.digit_sel == 2'b01) begin
        check("scan07_ones", bus.digit, 7);
        check("scan07_ones_blank", bus.blank, 0);
      end else begin
        check("scan07_tens", bus.digit, 0);
        check("scan07_tens_blank", bus.blank, 1);
      end
    end
    found = 0; first = 0;
    for (int i = 1; i < 4; i++)
      if (!found && s[i] != s[i-1]) begin found = 1; first = i; end
    check("scan_edge_found", found, 1);
    if (found)
      for (int j = 0; j < 9; j++) begin
        k = j / 3;
        check("scan_period", s[first + j], (k % 2 == 0) ? s[first] : (s[first] ^ 2'b11));
      end
    run_en(40);
    read_count("at17", t, o, bt);
    check("at17_tens", t, 1);
    check("at17_ones", o, 7);
    check("at17_tens_blank", bt, 0);

    // async reset between edges while tens slot is showing
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (bus.digit_sel == 2'b10) found = 1;
      else tick_n(1);
    end
    check("pre_rst_tens_slot", found, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_digit", bus.digit, 0);
    check("arst_sel", bus.digit_sel, 2'b01);
    check("arst_blank", bus.blank, 0);
    check("arst_wrap", bus.wrap, 0);
    tick_n(2);
    rst = 1'b0;
    expect_count("post_rst", 0, 0);
    run_en(4);
    expect_count("post_rst_step", 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
